// File: rtl/wma_rr_scheduler_if.sv
// Request/result bundle for the round-robin weighted-moving-average scheduler.
// The master side drives requests and downstream ready; the slave side is the scheduler.
interface wma_rr_scheduler_if #(
    parameter int N = 8
);
    logic [3:0]     req_valid;
    logic [4*N-1:0] req_data;
    logic [3:0]     req_ready;
    logic           flush;
    logic           out_valid;
    logic [N-1:0]   out_data;
    logic [1:0]     out_ch;
    logic           out_ready;
    logic           busy;

    modport master (
        output req_valid, req_data, flush, out_ready,
        input  req_ready, out_valid, out_data, out_ch, busy
    );

    modport slave (
        input  req_valid, req_data, flush, out_ready,
        output req_ready, out_valid, out_data, out_ch, busy
    );
endinterface

// File: rtl/wma_rr_scheduler.sv
// Four-channel round-robin scheduler sharing one weighted-moving-average datapath.
// Define WMA_SAT_EN to saturate the result at 2^N-1 instead of wrapping modulo 2^N.
module wma_rr_scheduler #(
    parameter int N = 8
) (
    input  logic               clk,
    input  logic               reset,
    wma_rr_scheduler_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE,
        CALC,
        OUT
    } state_t;

    state_t       stateQ;
    state_t       stateD;
    logic [1:0]   lastGrantQ;
    logic [N-1:0] xQ;
    logic [1:0]   chQ;
    logic [N-1:0] outDataQ;
    logic [1:0]   outChQ;
    logic [N-1:0] histQ [4][3];

    logic [N-1:0] chData [4];
    logic         grantFound;
    logic [1:0]   grantIdx;
    logic [1:0]   cand;
    logic [3:0]   grantVec;
    logic         handshake;
    logic [N+1:0] sumW;
    logic [N-1:0] result;

    // Search starts one past the last winner, so the previous winner has lowest priority.
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = '0;
        cand       = '0;
        for (int k = 1; k <= 4; k++) begin
            cand = lastGrantQ + 2'(k);
            if (!grantFound && bus.req_valid[cand]) begin
                grantFound = 1'b1;
                grantIdx   = cand;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            chData[i] = bus.req_data[i*N +: N];
        end
    end

    // Grants are only offered from IDLE with no flush pending and reset released.
    always_comb begin
        grantVec = '0;
        if (!reset && stateQ == IDLE && !bus.flush && grantFound) begin
            grantVec = 4'b0001 << grantIdx;
        end
        handshake = |grantVec;
    end

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            IDLE:    if (handshake) stateD = CALC;
            CALC:    stateD = OUT;
            OUT:     if (bus.out_ready) stateD = IDLE;
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    always_comb begin
        sumW = (N+2)'(xQ)
             + (N+2)'(histQ[chQ][0] >> 1)
             + (N+2)'(histQ[chQ][1] >> 2)
             + (N+2)'(histQ[chQ][2] >> 3);
`ifdef WMA_SAT_EN
        result = (sumW > {2'b00, {N{1'b1}}}) ? {N{1'b1}} : N'(sumW);
`else
        result = N'(sumW);
`endif
    end

    // History of the served channel shifts in CALC, together with capturing the result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lastGrantQ <= 2'd3;
            xQ         <= '0;
            chQ        <= '0;
            outDataQ   <= '0;
            outChQ     <= '0;
            for (int c = 0; c < 4; c++) begin
                for (int t = 0; t < 3; t++) begin
                    histQ[c][t] <= '0;
                end
            end
        end else begin
            if (handshake) begin
                xQ         <= chData[grantIdx];
                chQ        <= grantIdx;
                lastGrantQ <= grantIdx;
            end
            if (stateQ == IDLE && bus.flush) begin
                for (int c = 0; c < 4; c++) begin
                    for (int t = 0; t < 3; t++) begin
                        histQ[c][t] <= '0;
                    end
                end
            end
            if (stateQ == CALC) begin
                histQ[chQ][2] <= histQ[chQ][1];
                histQ[chQ][1] <= histQ[chQ][0];
                histQ[chQ][0] <= xQ;
                outDataQ      <= result;
                outChQ        <= chQ;
            end
        end
    end

    assign bus.req_ready = grantVec;
    assign bus.out_valid = (stateQ == OUT);
    assign bus.busy      = (stateQ != IDLE);
    assign bus.out_data  = outDataQ;
    assign bus.out_ch    = outChQ;
endmodule

// File: tb/tb_wma_rr_scheduler.sv
// Randomized bench for wma_rr_scheduler: a transaction-level model predicts grants and results,
// expected results are queued at grant time and a separate monitor compares them at the output.
module tb_wma_rr_scheduler;
    localparam int N    = 8;
    localparam int NCYC = 3000;
    localparam int MAXV = (1 << N) - 1;

    typedef struct {
        int ch;
        int data;
    } exp_t;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    exp_t expQ[$];

    int   hist [4][3];
    int   lastGrant;
    int   phase;

    wma_rr_scheduler_if #(.N(N)) bus ();

    wma_rr_scheduler #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] v, input logic [4*N-1:0] d,
                                 input logic f, input logic o);
        bus.req_valid = v;
        bus.req_data  = d;
        bus.flush     = f;
        bus.out_ready = o;
    endtask

    function automatic void modelReset();
        for (int c = 0; c < 4; c++)
            for (int t = 0; t < 3; t++)
                hist[c][t] = 0;
        lastGrant = 3;
        phase     = 0;
        expQ.delete();
    endfunction

    function automatic int pickData();
        int r;
        r = $urandom_range(0, 3);
        if (r == 0) return MAXV;
        if (r == 1) return 0;
        return $urandom_range(0, MAXV);
    endfunction

    // Output-side monitor: every presented result must match the oldest outstanding prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && bus.out_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_out_valid", 1, 0);
                end else begin
                    e = expQ[0];
                    checkOutput("out_ch", int'(bus.out_ch), e.ch);
                    checkOutput("out_data", int'(bus.out_data), e.data);
                    if (bus.out_ready) void'(expQ.pop_front());
                end
            end
        end
    end

    initial begin
        logic [3:0]     vIn;
        logic [4*N-1:0] dIn;
        logic           fIn;
        logic           oIn;
        logic           drain;
        int             expGrant;
        int             gIdx;
        int             s;
        int             dv [4];
        exp_t           e;

        errors = 0;
        checks = 0;
        modelReset();
        reset = 1'b1;
        applyStimulus(4'hF, '1, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_req_ready", int'(bus.req_ready), 0);
        checkOutput("reset_busy", int'(bus.busy), 0);
        checkOutput("reset_out_valid", int'(bus.out_valid), 0);
        checkOutput("reset_out_data", int'(bus.out_data), 0);
        checkOutput("reset_out_ch", int'(bus.out_ch), 0);
        @(negedge clk);
        reset = 1'b0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            drain = (cyc >= NCYC - 8);
            vIn   = drain ? 4'h0 : (($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(0, 15)));
            for (int i = 0; i < 4; i++) begin
                dv[i] = pickData();
                dIn[i*N +: N] = N'(dv[i]);
            end
            oIn = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
            fIn = !drain && ($urandom_range(0, 31) == 0);
            applyStimulus(vIn, dIn, fIn, oIn);
            #1;

            expGrant = 0;
            gIdx     = -1;
            if (phase == 0 && !fIn) begin
                for (int k = 1; k <= 4; k++) begin
                    if (gIdx < 0 && vIn[(lastGrant + k) % 4]) gIdx = (lastGrant + k) % 4;
                end
                if (gIdx >= 0) expGrant = 1 << gIdx;
            end
            checkOutput("req_ready", int'(bus.req_ready), expGrant);
            checkOutput("busy", int'(bus.busy), (phase != 0) ? 1 : 0);
            checkOutput("out_valid", int'(bus.out_valid), (phase == 2) ? 1 : 0);

            if (!drain && phase != 0 && $urandom_range(0, 63) == 0) begin
                reset = 1'b1;
                #1;
                checkOutput("midreset_out_valid", int'(bus.out_valid), 0);
                checkOutput("midreset_busy", int'(bus.busy), 0);
                modelReset();
                @(negedge clk);
                reset = 1'b0;
                continue;
            end

            case (phase)
                0: begin
                    if (fIn) begin
                        for (int c = 0; c < 4; c++)
                            for (int t = 0; t < 3; t++)
                                hist[c][t] = 0;
                    end else if (gIdx >= 0) begin
                        s = dv[gIdx] + hist[gIdx][0] / 2 + hist[gIdx][1] / 4 + hist[gIdx][2] / 8;
`ifdef WMA_SAT_EN
                        if (s > MAXV) s = MAXV;
`else
                        s = s % (MAXV + 1);
`endif
                        e.ch   = gIdx;
                        e.data = s;
                        expQ.push_back(e);
                        hist[gIdx][2] = hist[gIdx][1];
                        hist[gIdx][1] = hist[gIdx][0];
                        hist[gIdx][0] = dv[gIdx];
                        lastGrant = gIdx;
                        phase     = 1;
                    end
                end
                1: phase = 2;
                default: if (oIn) phase = 0;
            endcase
            @(negedge clk);
        end

        #3;
        checkOutput("drained_queue", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wma_rr_scheduler.md
WMA_RR_SCHEDULER -- requirements
Module: wma_rr_scheduler

Interface
REQ-001 Parameter: N, 8, sample width in bits (N >= 4).
REQ-002 clk  input  1  clock, all state updates on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  4  per-channel sample valid, bit i = channel i.
REQ-005 req_data  input  4*N  per-channel samples, channel i at bits [i*N+N-1 : i*N], unsigned.
REQ-006 req_ready  output  4  one-hot grant; channel i sample accepted when req_valid[i] and req_ready[i] are both high.
REQ-007 flush  input  1  synchronous clear of all channel histories.
REQ-008 out_valid  output  1  filtered result valid.
REQ-009 out_data  output  N  filtered result, unsigned.
REQ-010 out_ch  output  2  channel index of out_data.
REQ-011 out_ready  input  1  downstream accept; transfer when out_valid and out_ready are both high.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 The block SHALL time-share one weighted-moving-average datapath across 4 channels: y = x + floor(h1/2) + floor(h2/4) + floor(h3/8), where h1..h3 are that channel's previous three accepted samples, newest first.
REQ-014 The block SHALL keep a private 3-deep history per channel; an accepted sample SHALL shift only its own channel's history (h3<=h2, h2<=h1, h1<=x), in the CALC cycle.
REQ-015 FSM states SHALL be IDLE, CALC, OUT; IDLE->CALC on handshake, CALC->OUT unconditionally, OUT->IDLE on out_ready high, otherwise stay in OUT.
REQ-016 In IDLE with flush low, req_ready SHALL be combinationally the one-hot grant of the first channel with req_valid high, searching round-robin from (last_grant+1) mod 4; all zero if no request.
REQ-017 req_ready SHALL be all zero in CALC and OUT and whenever flush is high.
REQ-018 last_grant SHALL update to the granted channel on each handshake; reset value 3, so channel 0 has first priority.
REQ-019 The accepted sample and channel index SHALL be registered on the handshake edge; the sum SHALL be computed in CALC and registered into out_data/out_ch on the CALC->OUT edge.
REQ-020 Latency: handshake edge at end of cycle t -> out_valid high from cycle t+2; peak throughput one sample per 3 cycles with out_ready held high.
REQ-021 out_valid SHALL be high exactly in OUT; out_data and out_ch SHALL stay stable while out_valid is high and out_ready is low.
REQ-022 Sum SHALL be formed at N+2 bits internally; final N-bit reduction per REQ-030.
REQ-023 flush high in IDLE SHALL zero all 12 history registers at the next edge and block grants; flush in CALC or OUT SHALL be ignored.
REQ-024 A channel whose req_valid drops before grant SHALL not be granted; req_data is sampled only at handshake.

Reset
REQ-025 reset SHALL force state IDLE, last_grant 3, all histories 0, out_valid 0, out_data 0, out_ch 0, busy 0, req_ready 0 while asserted.
REQ-026 reset asserted in CALC or OUT SHALL discard the in-flight sample with no output transfer and no history update.
REQ-027 First edge after reset deassertion SHALL be able to accept a handshake.

Configuration
REQ-028 Macro WMA_SAT_EN selects result reduction.
REQ-029 With WMA_SAT_EN defined: out_data = min(sum, 2^N-1).
REQ-030 Without WMA_SAT_EN: out_data = sum mod 2^N (wrap, truncation).

Verification
REQ-031 N=8, ch0 sends 80,80,80,80 (out_ready=1) -> out_data 80,120,140,150, out_ch=0, each 2 cycles after its handshake.
REQ-032 All req_valid held high from reset, out_ready=1 -> grant order 0,1,2,3,0,1; one handshake every 3 cycles.
REQ-033 ch1 sends 64, ch2 sends 16, ch1 sends 0 -> outputs (ch1,64), (ch2,16), (ch1,32); ch2 history unaffected by ch1.
REQ-034 out_ready low for 5 cycles in OUT -> out_valid, out_data, out_ch stable, req_ready=0000, busy=1; release -> IDLE next cycle.
REQ-035 ch0 sends 255 x4 -> 4th output 220 without WMA_SAT_EN (476 mod 256), 255 with it; 2nd output 126 vs 255.
REQ-036 ch0 sends 200,200; flush 1 cycle in IDLE; ch0 sends 100 -> output 100; separately, reset in OUT -> out_valid 0 immediately, ch history 0.
